pmem_burst_adaptor: RTL and testbench

PMEM_BURST_ADAPTOR -- requirements
Module: pmem_burst_adaptor

---
 rtl/pmem_burst_adaptor.sv | 157 +++++++++++++++
 tb/tb_pmem_burst_adaptor.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/pmem_burst_adaptor.sv
// pmem_burst_adaptor
//   Bridges a cache's whole-line memory port to a narrower burst memory.
//   A line read is filled from s_line/s_burst consecutive memory beats.
//   A line write is split into the same number of beats, in the same order.
//   Beat k covers line bits [s_burst*k +: s_burst], so beat 0 is the least
//   significant slice.
//
//   Optional build macro: LINE_ADDR_ALIGN_EN
//     Defined     : the latched address has its byte-within-line bits cleared.
//     Not defined : the latched address is address_i unchanged.
//
// Ports
//   clk        clock; all state changes happen on the rising edge
//   rst        asynchronous, active-low reset
//   line_i     write-back line from the cache
//   line_o     most recently completed fill line; valid when resp_o=1
//   address_i  line address from the cache
//   read_i     cache line-read request
//   write_i    cache line-write request (read_i wins when both are high)
//   resp_o     one-cycle line-done pulse to the cache
//   burst_i    read beat from memory
//   burst_o    write beat to memory
//   address_o  burst address to memory (0 when no burst is active)
//   read_o     memory burst-read request
//   write_o    memory burst-write request
//   resp_i     memory beat acknowledge; one beat per high cycle
module pmem_burst_adaptor #(
  parameter int s_line  = 256,
  parameter int s_burst = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [s_line-1:0]  line_i,
  output logic [s_line-1:0]  line_o,
  input  logic [31:0]        address_i,
  input  logic               read_i,
  input  logic               write_i,
  output logic               resp_o,
  input  logic [s_burst-1:0] burst_i,
  output logic [s_burst-1:0] burst_o,
  output logic [31:0]        address_o,
  output logic               read_o,
  output logic               write_o,
  input  logic               resp_i
);

  localparam int BEATS    = s_line / s_burst;
  localparam int CW       = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int OFFSET_W = $clog2(s_line / 8);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t             state_reg, state_next;
  logic [CW-1:0]      count_reg;
  logic [31:0]        addr_reg;
  logic [31:0]        addr_latch;
  logic [s_line-1:0]  wdata_reg;
  logic [s_line-1:0]  fill_reg;
  logic [s_line-1:0]  fill_next;
  logic [s_line-1:0]  line_reg;
  logic [s_burst-1:0] wbeat [BEATS];
  logic               last_beat;

`ifdef LINE_ADDR_ALIGN_EN
  assign addr_latch = address_i & ~((32'd1 << OFFSET_W) - 32'd1);
`else
  assign addr_latch = address_i;
`endif

  assign last_beat = (count_reg == CW'(BEATS - 1));

  // Fill assembly lives in its own buffer so line_o keeps the previous line
  // until the new one is complete; the final beat is merged in via fill_next.
  for (genvar gi = 0; gi < BEATS; gi++) begin : g_beats
    assign wbeat[gi] = wdata_reg[gi*s_burst +: s_burst];
    assign fill_next[gi*s_burst +: s_burst] =
      (count_reg == CW'(gi)) ? burst_i : fill_reg[gi*s_burst +: s_burst];
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= IDLE;
    else      state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (read_i)       state_next = READ;
        else if (write_i) state_next = WRITE;
      end
      READ, WRITE: begin
        if (resp_i && last_beat) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs are decoded from state only, so they never depend on same-cycle inputs
  always_comb begin
    read_o    = 1'b0;
    write_o   = 1'b0;
    resp_o    = 1'b0;
    address_o = 32'd0;
    burst_o   = '0;
    case (state_reg)
      READ: begin
        read_o    = 1'b1;
        address_o = addr_reg;
      end
      WRITE: begin
        write_o   = 1'b1;
        address_o = addr_reg;
        burst_o   = wbeat[count_reg];
      end
      DONE:    resp_o = 1'b1;
      default: ;
    endcase
  end

  // Datapath: request capture, beat counting and fill assembly
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_reg <= '0;
      addr_reg  <= 32'd0;
      wdata_reg <= '0;
      fill_reg  <= '0;
      line_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (read_i || write_i) begin
            addr_reg  <= addr_latch;
            count_reg <= '0;
            if (!read_i) wdata_reg <= line_i;
          end
        end
        READ, WRITE: begin
          if (resp_i) begin
            count_reg <= last_beat ? '0 : count_reg + CW'(1);
            if (state_reg == READ) begin
              fill_reg <= fill_next;
              if (last_beat) line_reg <= fill_next;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign line_o = line_reg;

endmodule

// File: tb/tb_pmem_burst_adaptor.sv
module tb_pmem_burst_adaptor;

  localparam int SL = 256;
  localparam int SB = 64;
  localparam int NB = SL / SB;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [SL-1:0] line_i = '0;
  logic [SL-1:0] line_o;
  logic [31:0]   address_i = '0;
  logic          read_i = 1'b0;
  logic          write_i = 1'b0;
  logic          resp_o;
  logic [SB-1:0] burst_i = '0;
  logic [SB-1:0] burst_o;
  logic [31:0]   address_o;
  logic          read_o;
  logic          write_o;
  logic          resp_i = 1'b0;

  pmem_burst_adaptor #(.s_line(SL), .s_burst(SB)) dut (
    .clk(clk), .rst(rst),
    .line_i(line_i), .line_o(line_o),
    .address_i(address_i), .read_i(read_i), .write_i(write_i), .resp_o(resp_o),
    .burst_i(burst_i), .burst_o(burst_o), .address_o(address_o),
    .read_o(read_o), .write_o(write_o), .resp_i(resp_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            is_read;
    logic [SL-1:0] line;
  } exp_t;

  exp_t          exp_q[$];
  exp_t          mon_e;
  logic [31:0]   exp_addr = '0;
  int            n_checks = 0;
  int            n_errors = 0;

  task automatic check(input string tag, input logic [SL-1:0] got, input logic [SL-1:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, want);
    end
  endtask

  function automatic logic [31:0] line_addr(input logic [31:0] a);
`ifdef LINE_ADDR_ALIGN_EN
    return a & 32'hFFFF_FFE0;
`else
    return a;
`endif
  endfunction

  // Scoreboard side: every resp_o pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (rst) begin
      if (resp_o) begin
        if (exp_q.size() == 0) begin
          check("unexpected_resp_o", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          if (mon_e.is_read) check("line_o", line_o, mon_e.line);
          $display("txn %s done addr=%08h line_o=%064h",
                   mon_e.is_read ? "read " : "write", exp_addr, line_o);
        end
      end
      if (read_o || write_o) check("address_o", address_o, exp_addr);
    end
  end

  // Line read. waits: ack only every other cycle. hold: leave read_i high.
  // abort_after>0: pulse reset after that many beats and return.
  task automatic do_read(input logic [31:0] addr, input logic [SL-1:0] line,
                         input bit waits, input bit hold, input int abort_after);
    int k = 0;
    int c = 0;
    read_i    = 1'b1;
    address_i = addr;
    exp_addr  = line_addr(addr);
    exp_q.push_back('{1'b1, line});
    @(posedge clk); #1;
    if (!hold) read_i = 1'b0;
    write_i   = 1'b0;
    address_i = ~addr;
    while (k < NB && c < 40) begin
      check("read_o", read_o, 1);
      check("write_o_in_read", write_o, 0);
      resp_i  = !(waits && c[0] == 1'b0);
      burst_i = resp_i ? line[k*SB +: SB] : SB'({$urandom, $urandom});
      @(posedge clk); #1;
      if (resp_i) k++;
      c++;
      if (abort_after > 0 && k == abort_after) begin
        resp_i = 1'b0;
        rst    = 1'b0;
        #1;
        check("rst_read_o", read_o, 0);
        check("rst_resp_o", resp_o, 0);
        check("rst_address_o", address_o, 0);
        check("rst_line_o", line_o, 0);
        exp_q.delete();
        #2 rst = 1'b1;
        $display("txn read  aborted by reset after %0d beats", k);
        @(posedge clk); #1;
        return;
      end
    end
    resp_i = 1'b0;
    check("read_beats", k, NB);
    if (!waits) check("read_latency", c, NB);
    check("read_resp_o", resp_o, 1);
    check("read_o_in_done", read_o, 0);
    @(posedge clk); #1;
    check("read_resp_o_pulse", resp_o, 0);
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [SL-1:0] line, input bit waits);
    int k = 0;
    int c = 0;
    write_i   = 1'b1;
    address_i = addr;
    line_i    = line;
    exp_addr  = line_addr(addr);
    exp_q.push_back('{1'b0, line});
    @(posedge clk); #1;
    write_i   = 1'b0;
    address_i = ~addr;
    line_i    = ~line;
    while (k < NB && c < 40) begin
      check("write_o", write_o, 1);
      check("read_o_in_write", read_o, 0);
      check("burst_o", burst_o, line[k*SB +: SB]);
      resp_i = !(waits && c[0] == 1'b0);
      @(posedge clk); #1;
      if (resp_i) k++;
      c++;
    end
    resp_i = 1'b0;
    check("write_beats", k, NB);
    check("write_o_after_last", write_o, 0);
    check("write_resp_o", resp_o, 1);
    @(posedge clk); #1;
    check("write_resp_o_pulse", resp_o, 0);
  endtask

  logic [SL-1:0] line_a;
  logic [SL-1:0] line_w;
  logic [SL-1:0] line_r;

  initial begin
    line_a = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
              64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    line_w = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
              64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};

    #1;
    check("reset_read_o", read_o, 0);
    check("reset_write_o", write_o, 0);
    check("reset_resp_o", resp_o, 0);
    check("reset_address_o", address_o, 0);
    check("reset_burst_o", burst_o, 0);
    check("reset_line_o", line_o, 0);
    #13 rst = 1'b1;
    @(posedge clk); #1;

    // Minimum-latency read
    do_read(32'h0000_1040, line_a, 1'b0, 1'b0, 0);

    // Write with a wait state before every beat
    do_write(32'h0000_2000, line_w, 1'b1);
    check("line_o_held_over_write", line_o, line_a);

    // Read wins when both requests arrive together
    write_i = 1'b1;
    line_i  = line_w;
    line_r  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    do_read(32'h0000_3000, line_r, 1'b0, 1'b0, 0);

    // Unaligned address, read with wait states
    line_r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    do_read(32'h0000_105C, line_r, 1'b1, 1'b0, 0);

    // Reset after the 2nd beat, then a fresh minimum-latency read
    do_read(32'h0000_4000, line_a, 1'b0, 1'b0, 2);
    do_read(32'h0000_4000, line_a, 1'b0, 1'b0, 0);

    // read_i held through DONE: IDLE cycle must show no request before the next burst
    line_r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    do_read(32'h0000_5000, line_r, 1'b0, 1'b1, 0);
    check("idle_gap_read_o", read_o, 0);
    do_read(32'h0000_5020, line_a, 1'b0, 1'b0, 0);

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
